// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between the ALU and writeback.
// Decodes the access, steers byte/half lanes onto the word bus, runs a
// req/ready handshake with a wait-cycle timeout and returns extended load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (fault on misaligned half/word).
//
// state  | meaning
// IDLE   | waiting for start; decode happens here
// REQ    | mem_req asserted, waiting for mem_ready or timeout
// DONE   | one-cycle completion pulse (fault qualifies it)
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] load_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  // Last wait-counter value before the timeout fires.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        fault_q;
  logic [31:0] load_data_q;
  logic [7:0]  cnt_q;

  logic        dec_legal;
  logic        dec_fault;
  logic [31:0] dec_wdata;
  logic [3:0]  dec_wstrb;
  logic [31:0] ext_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        accept;
  logic        timeout_hit;

  assign accept      = (state_q == S_IDLE) && start_i;
  assign timeout_hit = (state_q == S_REQ) && !mem_ready_i && (cnt_q == WaitLast);

  // Decode the incoming access: legality, lane-replicated write data, strobes.
  always_comb begin
    dec_legal = 1'b0;
    dec_wdata = '0;
    dec_wstrb = '0;
    if (is_store_i) begin
      case (funct3_i)
        3'd0: begin
          dec_legal = 1'b1;
          dec_wdata = {4{store_data_i[7:0]}};
          dec_wstrb = 4'b0001 << addr_i[1:0];
        end
        3'd1: begin
          dec_legal = 1'b1;
          dec_wdata = {2{store_data_i[15:0]}};
          dec_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        3'd2: begin
          dec_legal = 1'b1;
          dec_wdata = store_data_i;
          dec_wstrb = 4'b1111;
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: dec_legal = 1'b1;
        default:                      dec_legal = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic dec_misalign;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  always_comb begin
    dec_misalign = 1'b0;
    case (funct3_i[1:0])
      2'd1:    dec_misalign = addr_i[0];
      2'd2:    dec_misalign = |addr_i[1:0];
      default: dec_misalign = 1'b0;
    endcase
  end

  assign dec_fault = !dec_legal || dec_misalign;
`else
  // Misaligned accesses proceed; low address bits beyond the lane are ignored.
  assign dec_fault = !dec_legal;
`endif

  // Select the addressed lane from the read word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = mem_rdata_i[7:0];
      2'd1:    lane_b = mem_rdata_i[15:8];
      2'd2:    lane_b = mem_rdata_i[23:16];
      default: lane_b = mem_rdata_i[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    ext_data = {{24{lane_b[7]}}, lane_b};
      3'd4:    ext_data = {24'd0, lane_b};
      3'd1:    ext_data = {{16{lane_h[15]}}, lane_h};
      3'd5:    ext_data = {16'd0, lane_h};
      default: ext_data = mem_rdata_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = dec_fault ? S_DONE : S_REQ;
      S_REQ:  if (mem_ready_i || timeout_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access context, wait counter and load result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else if (accept) begin
      we_q        <= is_store_i;
      funct3_q    <= funct3_i;
      off_q       <= addr_i[1:0];
      addr_q      <= {addr_i[31:2], 2'b00};
      wdata_q     <= dec_wdata;
      wstrb_q     <= dec_wstrb;
      fault_q     <= dec_fault;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else if (state_q == S_REQ) begin
      if (mem_ready_i) begin
        if (!we_q) load_data_q <= ext_data;
      end else if (timeout_hit) begin
        fault_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Output decode from state and held access context.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    fault_o     = (state_q == S_DONE) && fault_q;
    mem_req_o   = (state_q == S_REQ);
    mem_we_o    = (state_q == S_REQ) && we_q;
    load_data_o = load_data_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_wstrb_o = wstrb_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4): table of single accesses
// plus hand sequences for timeout, start-while-busy and mid-access reset.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        busy_o, done_o, fault_o;
  logic [31:0] load_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .load_data_o(load_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        exp_fault;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string name, logic st, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sd, logic [31:0] rdata, int waits, logic ef,
                              logic [31:0] ema, logic [31:0] ewd, logic [3:0] ews,
                              logic [31:0] eld);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
    v.waits = waits; v.exp_fault = ef; v.exp_maddr = ema; v.exp_wdata = ewd;
    v.exp_wstrb = ews; v.exp_load = eld;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, req_n, done_cyc;
    logic got_done, f;
    logic [31:0] ld;
    f = 1'b0; ld = '0;
    @(negedge clk_i);
    start_i = 1'b1; is_store_i = v.st; funct3_i = v.f3; addr_i = v.addr;
    store_data_i = v.sd; mem_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1; req_n = 0; got_done = 1'b0; done_cyc = 0;
    while (!got_done && cyc < 40) begin
      if (done_o) begin
        got_done = 1'b1; done_cyc = cyc; f = fault_o; ld = load_data_o;
        mem_ready_i = 1'b0;
      end else begin
        if (mem_req_o) begin
          req_n++;
          check({v.name, " mem_addr"}, mem_addr_o, v.exp_maddr);
          check({v.name, " mem_wdata"}, mem_wdata_o, v.exp_wdata);
          check({v.name, " mem_wstrb"}, 32'(mem_wstrb_o), 32'(v.exp_wstrb));
          check({v.name, " mem_we"}, 32'(mem_we_o), 32'(v.st));
          mem_ready_i = (req_n > v.waits);
          mem_rdata_i = v.rdata;
        end else begin
          mem_ready_i = 1'b0;
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    check({v.name, " done_seen"}, 32'(got_done), 32'd1);
    check({v.name, " done_cycle"}, done_cyc, v.exp_fault ? 32'd1 : 32'(v.waits + 2));
    check({v.name, " req_cycles"}, req_n, v.exp_fault ? 32'd0 : 32'(v.waits + 1));
    check({v.name, " fault"}, 32'(f), 32'(v.exp_fault));
    check({v.name, " load_data"}, ld, v.exp_load);
    @(negedge clk_i);
    check({v.name, " done_single"}, 32'(done_o), 32'd0);
    check({v.name, " load_held"}, load_data_o, v.exp_load);
  endtask

  initial begin
    int cyc, req_n, done_cyc;
    logic got_done, f;
    logic [31:0] ld;

    vecs[0]  = mk("lb_sign",   0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 32'h0000_1000, 32'h0, 4'h0, 32'hFFFF_FF80);
    vecs[1]  = mk("lhu_hi",    0, 3'd5, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 1, 0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_BEEF);
    vecs[2]  = mk("sb_lane1",  1, 3'd0, 32'h0000_0101, 32'h1234_56AB, 32'h0, 3, 0, 32'h0000_0100, 32'hABAB_ABAB, 4'b0010, 32'h0);
    vecs[3]  = mk("lh_sign",   0, 3'd1, 32'h0000_0200, 32'h0, 32'h1234_8001, 0, 0, 32'h0000_0200, 32'h0, 4'h0, 32'hFFFF_8001);
    vecs[4]  = mk("lbu_lane2", 0, 3'd4, 32'h0000_0002, 32'h0, 32'h11C3_2233, 2, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_00C3);
    vecs[5]  = mk("sh_hi",     1, 3'd1, 32'h0000_0302, 32'hAAAA_5678, 32'h0, 1, 0, 32'h0000_0300, 32'h5678_5678, 4'b1100, 32'h0);
    vecs[6]  = mk("sw",        1, 3'd2, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 2, 0, 32'h0000_0400, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    vecs[7]  = mk("lw",        0, 3'd2, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 0, 0, 32'h0000_0500, 32'h0, 4'h0, 32'hCAFE_F00D);
    vecs[8]  = mk("ill_load",  0, 3'd3, 32'h0000_0010, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0);
    vecs[9]  = mk("ill_store", 1, 3'd4, 32'h0000_0020, 32'h5555_5555, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = mk("lw_misal",  0, 3'd2, 32'h0000_0102, 32'h0, 32'h0102_0304, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0);
`else
    vecs[10] = mk("lw_misal",  0, 3'd2, 32'h0000_0102, 32'h0, 32'h0102_0304, 0, 0, 32'h0000_0100, 32'h0, 4'h0, 32'h0102_0304);
`endif
    vecs[11] = mk("lb_pos",    0, 3'd0, 32'h0000_0000, 32'h0, 32'h0000_007F, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_007F);

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst fault", 32'(fault_o), 32'd0);
    check("rst mem_req", 32'(mem_req_o), 32'd0);
    check("rst mem_we", 32'(mem_we_o), 32'd0);
    check("rst load_data", load_data_o, 32'd0);
    check("rst mem_addr", mem_addr_o, 32'd0);
    check("rst mem_wdata", mem_wdata_o, 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb_o), 32'd0);
    rst_n_i = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Timeout on a store; start held through REQ and DONE must be ignored.
    @(negedge clk_i);
    start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h0000_0700;
    store_data_i = 32'h55AA_55AA; mem_ready_i = 1'b0;
    @(negedge clk_i);
    is_store_i = 1'b0; funct3_i = 3'd0; addr_i = 32'h0000_0903;
    cyc = 1; req_n = 0; got_done = 1'b0; done_cyc = 0; f = 1'b0; ld = '1;
    while (!got_done && cyc < 40) begin
      if (done_o) begin
        got_done = 1'b1; done_cyc = cyc; f = fault_o; ld = load_data_o;
      end else begin
        if (mem_req_o) begin
          req_n++;
          check("to mem_addr", mem_addr_o, 32'h0000_0700);
          check("to mem_wstrb", 32'(mem_wstrb_o), 32'hF);
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    check("to done_seen", 32'(got_done), 32'd1);
    check("to done_cycle", done_cyc, 32'd5);
    check("to req_cycles", req_n, 32'd4);
    check("to fault", 32'(f), 32'd1);
    check("to load_data", ld, 32'd0);
    @(negedge clk_i);
    check("to start_at_done_ignored", 32'(busy_o), 32'd0);
    start_i = 1'b0;

    // Asynchronous reset in the middle of a request.
    @(negedge clk_i);
    start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h0000_0600;
    @(negedge clk_i);
    start_i = 1'b0;
    check("mid req_before", 32'(mem_req_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("mid req_dropped", 32'(mem_req_o), 32'd0);
    check("mid busy_dropped", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("mid no_done", 32'(done_o), 32'd0);
    rst_n_i = 1'b1;
    run_vec(mk("lw_after_rst", 0, 3'd2, 32'h0000_0800, 32'h0, 32'h0BAD_CAFE, 1, 0,
               32'h0000_0800, 32'h0, 4'h0, 32'h0BAD_CAFE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the ALU in the RISC-V core. It takes the effective address computed by the ALU for LOAD_TYPE/S_TYPE instructions, runs a request/ready handshake with data memory, and returns sign- or zero-extended load data to writeback. Byte/halfword lane steering, write strobes and access faults are handled here, so the ALU and register file see only 32-bit words.

## Interface
- `TIMEOUT`, default 255: maximum cycles in REQ waiting for `mem_ready` before faulting (1..255).
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin access; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: access size/sign code from the instruction.
- `addr` in 32: effective address (ALU output).
- `store_data` in 32: rs2 value.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; 1 = access aborted.
- `load_data` out 32: extended load result; valid with `done`, held until next accepted `start`.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word-aligned address (`addr[31:2]`, 2'b00).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte write strobes (0 for loads).
- `mem_ready` in 1: memory accepts/completes the request this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` high on a load.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on `start`, latch `is_store`, `funct3`, `addr`, `store_data`; decode; illegal or faulting access -> DONE with fault; otherwise -> REQ. `start` outside IDLE is ignored.
- REQ: `mem_req`=1; `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` held stable from latched values. On `mem_ready`: capture/extract load data, -> DONE. Wait counter increments each REQ cycle without `mem_ready`; on reaching `TIMEOUT` -> DONE with fault, request dropped.
- DONE: `done`=1 for exactly one cycle, -> IDLE.
- Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Byte lane = `addr[1:0]`, half lane = `addr[1]`. LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
- Stores: 0 SB, 1 SH, 2 SW. SB: wdata = 4 copies of `store_data[7:0]`, wstrb = 1 << `addr[1:0]`. SH: wdata = 2 copies of `store_data[15:0]`, wstrb = 0011 (`addr[1]`=0) or 1100. SW: wdata = `store_data`, wstrb = 1111.
- Illegal funct3 (load 3,6,7; store 3..7): fault, no `mem_req`.
- On fault, `load_data` = 0 and no memory side effect.

## Timing
- Reset: state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `load_data`, `mem_addr`, `mem_wdata` = 0; `mem_wstrb` = 0; wait counter 0. Reset mid-access drops `mem_req` immediately (asynchronous), no `done`.
- `start` at cycle 0 -> `mem_req` high from cycle 1; `mem_ready` at cycle k -> `mem_req` low and `done` high at cycle k+1. Minimum start-to-done: 2 cycles.
- Fault detected at decode: `done`+`fault` at cycle 1, no `mem_req`.
- Timeout: `done`+`fault` the cycle after `TIMEOUT` consecutive REQ cycles without `mem_ready`.
- `start` coincident with `done` is ignored; next `start` accepted in the following IDLE cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`!=0, fault at decode with no memory access.
- Undefined: no misalignment fault; low address bits ignored for the access size (half uses lane `addr[1]`, word uses full word), access proceeds normally.

## Test plan
- LB `addr`=0x1003, `mem_rdata`=0x80FF1234 ready on first REQ cycle -> `done` at cycle 2, `load_data`=0xFFFFFF80, `fault`=0.
- LHU `addr`=0x0102, `mem_rdata`=0xBEEF0000 -> `load_data`=0x0000BEEF; `mem_addr`=0x0100, `mem_wstrb`=0000.
- SB `addr`=0x0101, `store_data`=0x123456AB, `mem_ready` after 3 wait cycles -> `mem_wdata`=0xABABABAB, `mem_wstrb`=0010 stable all REQ cycles, `done` once.
- LW `addr`=0x0102 -> with macro: `fault`=1 at cycle 1, `mem_req` never high; without: `mem_addr`=0x0100, `load_data`=`mem_rdata`.
- `TIMEOUT`=4, SW with `mem_ready` held 0 -> `mem_req` high 4 cycles, then `done`+`fault`=1; `start` during REQ ignored.
- `rst_n` low during REQ -> `mem_req`, `busy` drop asynchronously; after release, new LW completes normally.
